regfile_commit: RTL and testbench
=================================

# regfile_commit

Register-file commit stage sitting directly downstream of the write-back result selector. It accepts one selected result per handshake, writes it into a 16-entry × 16-bit general register file, and provides two read ports for operand fetch. A 32-bit MUL product is committed over two cycles (low half to `rd`, high half to `rd+1`), stalling the producer for one cycle. The stage also keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- `NUM_REGS`, 16: register count; power of two; index width `AW = log2(NUM_REGS)`.
- `DATA_W`, 16: register width; product input is `2*DATA_W`.
- `clk  in  1`: single clock; all state changes on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `wb_valid  in  1`: result presented.
- `wb_ready  out  1`: stage can accept; `wb_ready = (state==IDLE) && !rst`.
- `wb_op  in  6`: opcode of the instruction being committed.
- `wb_rd  in  AW`: destination register.
- `wb_data  in  2*DATA_W`: result; only `[DATA_W-1:0]` is used except for MUL.
- `rs1_addr`, `rs2_addr  in  AW`: read addresses.
- `rs1_data`, `rs2_data  out  DATA_W`: combinational read data with write-first bypass.
- `retire_cnt  out  16`: count of accepted instructions.
- `illegal_op  out  1`: sticky; set by any accepted opcode above 010000.

## Operation
- Accept = `wb_valid && wb_ready` at a rising edge.
- Opcode classes:
  - Single write, `reg[wb_rd] <= wb_data[15:0]`: 000000 and 000001 (MOV), 000010 (LOAD), 000100–000110, and 001000–010000.
  - No write, accepted and retired: 000011 (STORE).
  - MUL, 000111:
    - On accept: `reg[wb_rd] <= wb_data[15:0]`, latch `hi <= wb_data[31:16]`, latch `hi_rd <= (wb_rd+1) mod NUM_REGS`, go to HI.
    - `wb_rd = 15` wraps `hi_rd` to 0.
  - Illegal, 010001–111111: accepted, no write, `illegal_op <= 1`.
- State machine:
  - IDLE: accepts; MUL moves to HI, every other opcode stays in IDLE.
  - HI: `wb_ready = 0`; writes `reg[hi_rd] <= hi`; returns to IDLE unconditionally next edge.
- Only one register write port. In HI the only write is `hi_rd`.
- Read ports:
  - `rsN_data = reg[rsN_addr]`, unless a write to `rsN_addr` is committing this cycle; then the output is the write data (write-first bypass).
  - Applies to both the IDLE write and the HI write.
- `retire_cnt` increments by 1 on every accept, including MUL, STORE and illegal opcodes. MUL counts once, at accept. The counter wraps 0xFFFF → 0x0000.
- `illegal_op` is cleared only by `rst`.
- All register indices are writable; no hardwired-zero register.

## Timing
- Reset (edge with `rst=1`):
  - All registers 0; state IDLE; `hi`/`hi_rd` 0; `retire_cnt` 0; `illegal_op` 0.
  - `wb_ready` is 0 while `rst` is high and 1 on the first cycle after.
  - No write is performed on a reset edge, even if `wb_valid` is high.
- Single-write latency: register updated at the accept edge; visible via array read on the next cycle; visible through bypass in the accept cycle itself.
- MUL:
  - Low half written at the accept edge (cycle N); high half written at edge N+1.
  - `wb_ready` is low during cycle N+1 only; the next accept is possible at edge N+2.
- Reset during HI: the pending high-half write is discarded, all registers are zeroed, and state goes to IDLE.
- `wb_valid` asserted while `wb_ready=0` is ignored. The producer must hold `wb_op`, `wb_rd` and `wb_data` stable until accepted.
- Back-to-back non-MUL accepts sustain one per cycle.
- MUL with `wb_rd+1` equal to `rsN_addr` during cycle N+1: the bypass returns `hi`.

## Test plan
- Reset then ADD: after `rst`, all reads return 0. Accept `op=000100`, `rd=3`, `data=0x00001234`; `rs1_addr=3` shows 0x1234 in the same cycle (bypass) and the next cycle. `retire_cnt=1`.
- MUL wrap: accept `op=000111`, `rd=15`, `data=0xDEADBEEF`. Then `reg15=0xBEEF`, `reg0=0xDEAD` one cycle later, `wb_ready` low for exactly one cycle, and `retire_cnt` increments by 1.
- STORE and illegal:
  - `op=000011`, `rd=5`, `data=0xFFFF`: `reg5` stays 0, `retire_cnt` increments.
  - `op=010001`: no write; `illegal_op=1` and it stays 1 until `rst`.
- Stall hold: MUL followed immediately by ADD held valid (`rd=2`, `data=0x0007`). The ADD is accepted only at edge N+2 and `reg2=0x0007`; nothing is lost or duplicated.
- Reset mid-MUL: accept MUL `rd=4`, `data=0x11112222`, assert `rst` in the HI cycle. All registers read 0, `reg5` stays 0, `retire_cnt=0`, and `wb_ready` is 1 the cycle after `rst` drops.
- Counter wrap: 65536 back-to-back MOVs end with `retire_cnt=0x0000`. Streaming at one instruction per cycle, each `rd` holds its last written value.

Source files
------------

// File: rtl/regfile_commit.sv
// Write-back commit stage: 16x16 register file with a single write port, two
// bypassed read ports, a two-cycle MUL commit, a retire counter and a sticky illegal flag.
module regfile_commit #(
    parameter  int unsigned NUM_REGS = 16,
    parameter  int unsigned DATA_W   = 16,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [5:0]            wb_op,
    input  logic [AW-1:0]         wb_rd,
    input  logic [2*DATA_W-1:0]   wb_data,
    input  logic [AW-1:0]         rs1_addr,
    input  logic [AW-1:0]         rs2_addr,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    output logic [15:0]           retire_cnt,
    output logic                  illegal_op
);

    localparam logic [5:0] OpStore    = 6'd3;
    localparam logic [5:0] OpMul      = 6'd7;
    localparam logic [5:0] OpMaxLegal = 6'd16;

    typedef enum logic [0:0] {StIdle, StHi} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [AW-1:0]       hi_rd_q, hi_rd_d;
    logic [15:0]         retire_cnt_q, retire_cnt_d;
    logic                illegal_op_q, illegal_op_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                accept;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   wdata;

    assign wb_ready = (state_q == StIdle) && !rst;
    assign accept   = wb_valid && wb_ready;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        hi_rd_d      = hi_rd_q;
        retire_cnt_d = retire_cnt_q;
        illegal_op_d = illegal_op_q;
        we           = 1'b0;
        waddr        = '0;
        wdata        = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    retire_cnt_d = retire_cnt_q + 16'd1;
                    if (wb_op > OpMaxLegal) begin
                        illegal_op_d = 1'b1;
                    end else if (wb_op != OpStore) begin
                        we    = 1'b1;
                        waddr = wb_rd;
                        wdata = wb_data[DATA_W-1:0];
                    end
                    if (wb_op == OpMul) begin
                        state_d = StHi;
                        hi_d    = wb_data[2*DATA_W-1:DATA_W];
                        hi_rd_d = wb_rd + 1'b1;
                    end
                end
            end
            StHi: begin
                // A reset in this cycle discards the high half, bypass included.
                we      = !rst;
                waddr   = hi_rd_q;
                wdata   = hi_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    // Write-first bypass on both read ports.
    assign rs1_data = (we && (waddr == rs1_addr)) ? wdata : regs_q[rs1_addr];
    assign rs2_data = (we && (waddr == rs2_addr)) ? wdata : regs_q[rs2_addr];

    assign retire_cnt = retire_cnt_q;
    assign illegal_op = illegal_op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hi_q         <= '0;
            hi_rd_q      <= '0;
            retire_cnt_q <= '0;
            illegal_op_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            hi_rd_q      <= hi_rd_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_op_q <= illegal_op_d;
            regs_q       <= regs_d;
        end
    end

endmodule

// File: tb/tb_regfile_commit.sv
// Self-checking bench for regfile_commit: directed scenarios plus randomized traffic
// checked against an architectural model of the register file.
module tb_regfile_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [5:0]  wb_op;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [15:0] rs1_data, rs2_data;
    logic [15:0] retire_cnt;
    logic        illegal_op;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model: the whole instruction's effect is applied at once.
    logic [15:0] m_regs [16];
    logic [15:0] m_cnt;
    logic        m_ill;

    regfile_commit #(.NUM_REGS(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_op      (wb_op),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .retire_cnt (retire_cnt),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_cnt = 16'h0;
        m_ill = 1'b0;
    endtask

    task automatic model_accept(input logic [5:0] op, input logic [3:0] rd,
                                input logic [31:0] d);
        logic [3:0] rd1;
        m_cnt = m_cnt + 16'd1;
        rd1   = rd + 4'd1;
        if (op == 6'd7) begin
            m_regs[rd]  = d[15:0];
            m_regs[rd1] = d[31:16];
        end else if (op > 6'd16) begin
            m_ill = 1'b1;
        end else if (op != 6'd3) begin
            m_regs[rd] = d[15:0];
        end
    endtask

    // Present one instruction, wait for acceptance, and let a MUL finish its high half.
    task automatic send(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] d);
        int waited = 0;
        wb_op = op; wb_rd = rd; wb_data = d; wb_valid = 1'b1;
        #1;
        while (!wb_ready && waited < 4) begin
            tick();
            waited++;
        end
        if (!wb_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: wb_ready=%0b after %0d cycles, required 1", wb_ready,
                     waited);
        end
        tick();
        model_accept(op, rd, d);
        wb_valid = 1'b0;
        if (op == 6'd7) tick();
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
        rs1_addr = a;
        #1;
        v = rs1_data;
    endtask

    task automatic do_reset;
        rst = 1'b1; wb_valid = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] v;
        rst = 1'b1; wb_valid = 1'b1; wb_op = 6'd4; wb_rd = 4'd1; wb_data = 32'h0000_5555;
        tick();
        tick();
        n_tests++;
        if (wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %0b, required 0", wb_ready);
        end
        rst = 1'b0; wb_valid = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (wb_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_high: got %0b, required 1", wb_ready);
        end
        for (int i = 0; i < 16; i++) begin
            rs2_addr = 4'(15 - i);
            rd_reg(4'(i), v);
            n_tests++;
            if (v !== 16'h0 || rs2_data !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_regs: r%0d=%h r%0d=%h, required 0", i, v, 15 - i, rs2_data);
            end
        end
        n_tests++;
        if (retire_cnt !== 16'h0 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt_ill: cnt=%h ill=%0b, required 0/0", retire_cnt, illegal_op);
        end
    endtask

    task automatic test_add;
        logic [15:0] v;
        rs1_addr = 4'd3;
        wb_op = 6'd4; wb_rd = 4'd3; wb_data = 32'h0000_1234; wb_valid = 1'b1;
        #1;
        n_tests++;
        if (rs1_data !== 16'h1234) begin
            n_fail++; $display("FAIL add_bypass: got %h, required 1234", rs1_data);
        end
        tick();
        model_accept(6'd4, 4'd3, 32'h0000_1234);
        wb_valid = 1'b0;
        rd_reg(4'd3, v);
        n_tests++;
        if (v !== 16'h1234 || retire_cnt !== 16'd1) begin
            n_fail++; $display("FAIL add_commit: r3=%h cnt=%h, required 1234/0001", v, retire_cnt);
        end
    endtask

    task automatic test_mul_wrap;
        logic [15:0] cnt0;
        cnt0 = m_cnt;
        rs1_addr = 4'd15; rs2_addr = 4'd0;
        wb_op = 6'd7; wb_rd = 4'd15; wb_data = 32'hDEAD_BEEF; wb_valid = 1'b1;
        #1;
        n_tests++;
        if (rs1_data !== 16'hBEEF || rs2_data !== m_regs[0]) begin
            n_fail++;
            $display("FAIL mul_accept_cycle: r15=%h r0=%h, required beef/%h", rs1_data,
                     rs2_data, m_regs[0]);
        end
        tick();
        model_accept(6'd7, 4'd15, 32'hDEAD_BEEF);
        wb_valid = 1'b0;
        n_tests++;
        if (wb_ready !== 1'b0 || rs1_data !== 16'hBEEF || rs2_data !== 16'hDEAD) begin
            n_fail++;
            $display("FAIL mul_hi_cycle: ready=%0b r15=%h r0=%h, required 0/beef/dead",
                     wb_ready, rs1_data, rs2_data);
        end
        tick();
        n_tests++;
        if (wb_ready !== 1'b1 || rs2_data !== 16'hDEAD || retire_cnt !== cnt0 + 16'd1) begin
            n_fail++;
            $display("FAIL mul_after: ready=%0b r0=%h cnt=%h, required 1/dead/%h", wb_ready,
                     rs2_data, retire_cnt, cnt0 + 16'd1);
        end
    endtask

    task automatic test_store_illegal;
        logic [15:0] v;
        n_tests++;
        if (illegal_op !== 1'b0) begin
            n_fail++; $display("FAIL ill_initial: got %0b, required 0", illegal_op);
        end
        send(6'd3, 4'd5, 32'h0000_FFFF);
        rd_reg(4'd5, v);
        n_tests++;
        if (v !== 16'h0 || retire_cnt !== m_cnt) begin
            n_fail++; $display("FAIL store: r5=%h cnt=%h, required 0000/%h", v, retire_cnt, m_cnt);
        end
        send(6'd17, 4'd6, 32'h0000_AAAA);
        rd_reg(4'd6, v);
        n_tests++;
        if (v !== m_regs[6] || illegal_op !== 1'b1 || retire_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL illegal: r6=%h ill=%0b cnt=%h, required %h/1/%h", v, illegal_op,
                     retire_cnt, m_regs[6], m_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            send(6'($urandom_range(0, 16)), 4'($urandom_range(0, 15)), $urandom);
        end
        n_tests++;
        if (illegal_op !== 1'b1) begin
            n_fail++; $display("FAIL ill_sticky: got %0b, required 1", illegal_op);
        end
    endtask

    task automatic test_stall_hold;
        logic [15:0] v;
        logic [31:0] d;
        d = $urandom;
        wb_op = 6'd7; wb_rd = 4'd8; wb_data = d; wb_valid = 1'b1;
        tick();
        model_accept(6'd7, 4'd8, d);
        wb_op = 6'd4; wb_rd = 4'd2; wb_data = 32'h0000_0007;
        n_tests++;
        if (wb_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready: got %0b, required 0", wb_ready);
        end
        tick();
        n_tests++;
        if (wb_ready !== 1'b1 || retire_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL stall_n2: ready=%0b cnt=%h, required 1/%h", wb_ready, retire_cnt, m_cnt);
        end
        tick();
        model_accept(6'd4, 4'd2, 32'h0000_0007);
        wb_valid = 1'b0;
        rs2_addr = 4'd9;
        rd_reg(4'd2, v);
        n_tests++;
        if (v !== 16'h0007 || retire_cnt !== m_cnt || rs2_data !== d[31:16]) begin
            n_fail++;
            $display("FAIL stall_commit: r2=%h cnt=%h r9=%h, required 0007/%h/%h", v,
                     retire_cnt, rs2_data, m_cnt, d[31:16]);
        end
        rd_reg(4'd8, v);
        n_tests++;
        if (v !== d[15:0]) begin
            n_fail++; $display("FAIL stall_mul_lo: r8=%h, required %h", v, d[15:0]);
        end
    endtask

    task automatic test_random_mix;
        logic [15:0] v;
        logic [3:0]  a;
        for (int i = 0; i < 200; i++) begin
            send(6'($urandom_range(0, 20)), 4'($urandom_range(0, 15)), $urandom);
            a = 4'($urandom_range(0, 15));
            rd_reg(a, v);
            n_tests++;
            if (v !== m_regs[a]) begin
                n_fail++; $display("FAIL random_read: r%0d=%h, required %h", a, v, m_regs[a]);
            end
        end
        n_tests++;
        if (retire_cnt !== m_cnt || illegal_op !== m_ill) begin
            n_fail++;
            $display("FAIL random_state: cnt=%h ill=%0b, required %h/%0b", retire_cnt,
                     illegal_op, m_cnt, m_ill);
        end
    endtask

    task automatic test_reset_mid_mul;
        logic [15:0] v;
        wb_op = 6'd7; wb_rd = 4'd4; wb_data = 32'h1111_2222; wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0; rst = 1'b1;
        rs2_addr = 4'd5;
        #1;
        n_tests++;
        if (rs2_data === 16'h1111) begin
            n_fail++; $display("FAIL rst_hi_bypass: r5=%h, required not 1111", rs2_data);
        end
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (wb_ready !== 1'b1 || retire_cnt !== 16'h0 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_state: ready=%0b cnt=%h ill=%0b, required 1/0000/0",
                     wb_ready, retire_cnt, illegal_op);
        end
        for (int i = 0; i < 16; i++) begin
            rd_reg(4'(i), v);
            n_tests++;
            if (v !== 16'h0) begin
                n_fail++; $display("FAIL rst_mid_regs: r%0d=%h, required 0000", i, v);
            end
        end
        tick();
        rd_reg(4'd5, v);
        n_tests++;
        if (v !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid_r5: r5=%h, required 0000", v);
        end
    endtask

    task automatic test_counter_wrap;
        logic [15:0] v;
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [31:0] d;
        int          stalls = 0;
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            op = 6'($urandom_range(0, 1));
            rd = 4'($urandom_range(0, 15));
            d  = $urandom;
            wb_op = op; wb_rd = rd; wb_data = d; wb_valid = 1'b1;
            if (wb_ready !== 1'b1) stalls++;
            tick();
            model_accept(op, rd, d);
        end
        wb_valid = 1'b0;
        #1;
        n_tests++;
        if (retire_cnt !== 16'h0000 || m_cnt !== 16'h0000 || stalls != 0) begin
            n_fail++;
            $display("FAIL counter_wrap: cnt=%h stalls=%0d, required 0000/0", retire_cnt, stalls);
        end
        for (int i = 0; i < 16; i++) begin
            rd_reg(4'(i), v);
            n_tests++;
            if (v !== m_regs[i]) begin
                n_fail++; $display("FAIL stream_regs: r%0d=%h, required %h", i, v, m_regs[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_op = '0; wb_rd = '0; wb_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        model_reset();
        test_reset();
        test_add();
        test_mul_wrap();
        test_store_illegal();
        test_stall_hold();
        test_random_mix();
        test_reset_mid_mul();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
